// File: rtl/pair_bus_sequencer.sv
// rtl/pair_bus_sequencer.sv - FIFO-buffered 2-bit pair-bus symbol player with per-symbol hold
module pair_bus_sequencer #(
    parameter int DEPTH  = 8,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [1:0]        wr_sym,
    output logic              wr_ready,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold,
    output logic              busy,
    output logic              done,
    output logic [1:0]        a,
    output logic              a1,
    output logic              a0,
    output logic              changed
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [1:0]        mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              fifo_empty;
    logic [1:0]        head;

    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_r_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;

    logic              push;
    logic              pop;
    logic              done_nxt;
    logic [1:0]        a_r;
    logic              changed_r;
    logic              done_r;

    assign fifo_empty = (count == '0);
    assign wr_ready   = (count != CW'(DEPTH));
    assign push       = wr_valid && wr_ready;
    assign head       = mem[rd_ptr];

    assign busy    = (state == PLAY);
    assign done    = done_r;
    assign a       = a_r;
    assign a1      = a_r[1];
    assign a0      = a_r[0];
    assign changed = changed_r;

    // Next-state logic: decides when to pop a symbol, reload the hold counter or finish.
    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        done_nxt     = 1'b0;
        hold_r_nxt   = hold_r;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE: begin
                if (start && !fifo_empty) begin
                    pop          = 1'b1;
                    hold_r_nxt   = hold;
                    hold_cnt_nxt = hold;
                    state_nxt    = PLAY;
                end
            end
            PLAY: begin
                if (hold_cnt != '0) begin
                    hold_cnt_nxt = hold_cnt - HOLD_W'(1);
                end else if (!fifo_empty) begin
                    // Only symbols already queued before this edge are eligible.
                    pop          = 1'b1;
                    hold_cnt_nxt = hold_r;
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register together with the latched hold value and the running hold counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_r   <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            hold_r   <= hold_r_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // FIFO bookkeeping; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_sym;
    end

    // Output registers: bus symbol, change pulse and end-of-playout pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r       <= 2'b00;
            changed_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r    <= done_nxt;
            changed_r <= pop && (head != a_r);
            if (pop) a_r <= head;
        end
    end

endmodule
